// File: rtl/qdma_desc_sched_pkg.sv
// Shared types and constants for the QDMA descriptor scheduler slice.
package qdma_sched_pkg;

    typedef enum logic {
        IDLE,
        ISSUE
    } sched_state_e;

    localparam int unsigned STAT_WIDTH = 32;
    localparam int unsigned BURST_W    = 8;

endpackage

// File: rtl/qdma_desc_sched_if.sv
// Counter-bank and DMA request signals of the descriptor scheduler.
interface qdma_desc_sched_if #(
    parameter int unsigned NUM_Q     = 8,
    parameter int unsigned QID_WIDTH = 3
);

    logic [NUM_Q-1:0]     q_desc_rdy;
    logic [NUM_Q-1:0]     q_en;
    logic [NUM_Q-1:0]     q_desc_dec;
    logic                 req_vld;
    logic                 req_rdy;
    logic [QID_WIDTH-1:0] req_qid;
    logic                 req_last;
    logic                 req_abort;
    logic                 sched_busy;

    modport master (
        input  q_desc_rdy, q_en, req_rdy,
        output q_desc_dec, req_vld, req_qid, req_last, req_abort, sched_busy
    );

    modport slave (
        output q_desc_rdy, q_en, req_rdy,
        input  q_desc_dec, req_vld, req_qid, req_last, req_abort, sched_busy
    );

endinterface

// File: rtl/qdma_desc_sched_rr_pick.sv
// Combinational rotating priority encoder: first set bit of elig at or above start, wrapping at NUM_Q.
module rr_pick #(
    parameter int unsigned NUM_Q     = 8,
    parameter int unsigned QID_WIDTH = 3
) (
    input  logic [NUM_Q-1:0]     elig,
    input  logic [QID_WIDTH-1:0] start,
    output logic                 found,
    output logic [QID_WIDTH-1:0] qid
);

    localparam logic [QID_WIDTH:0] NUM_Q_W = (QID_WIDTH+1)'(NUM_Q);

    logic [2*NUM_Q-1:0] dbl;
    logic [NUM_Q-1:0]   rot;
    logic [QID_WIDTH:0] off;
    logic [QID_WIDTH:0] sum;

    // Doubling the vector turns the wrapping search into a plain LSB-first scan.
    assign dbl = {elig, elig} >> start;
    assign rot = dbl[NUM_Q-1:0];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = (QID_WIDTH+1)'(i);
            end
        end
    end

    assign sum = {1'b0, start} + off;
    assign qid = (sum >= NUM_Q_W) ? QID_WIDTH'(sum - NUM_Q_W) : sum[QID_WIDTH-1:0];

endmodule

// File: rtl/qdma_desc_sched.sv
// Round-robin descriptor scheduler between the counter bank and the MM DMA request port.
// Optional per-queue request statistics: define QDMA_DESC_SCHED_STATS_EN.
module qdma_desc_sched
    import qdma_sched_pkg::*;
#(
    parameter int unsigned NUM_Q     = 8,
    parameter int unsigned QID_WIDTH = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   user_clk,
    input  logic                   user_reset,
    qdma_desc_sched_if.master      sched_if
`ifdef QDMA_DESC_SCHED_STATS_EN
    ,
    input  logic [QID_WIDTH-1:0]   stat_qid,
    output logic [STAT_WIDTH-1:0]  stat_cnt,
    input  logic                   stat_clr
`endif
);

    localparam logic [QID_WIDTH-1:0] LAST_Q     = QID_WIDTH'(NUM_Q - 1);
    localparam logic [BURST_W-1:0]   BURST_LAST = BURST_W'(MAX_BURST - 1);

    sched_state_e         state, state_d;
    logic [QID_WIDTH-1:0] rr_ptr, rr_ptr_d;
    logic [QID_WIDTH-1:0] req_qid, req_qid_d;
    logic [BURST_W-1:0]   burst_cnt, burst_cnt_d;
    logic [QID_WIDTH-1:0] next_q;
    logic [QID_WIDTH-1:0] pick_qid;
    logic                 pick_found;
    logic [NUM_Q-1:0]     elig;
    logic [NUM_Q-1:0]     dec;
    logic                 cur_ok;
    logic                 abort;

    assign elig   = sched_if.q_desc_rdy & sched_if.q_en;
    assign cur_ok = elig[req_qid];
    assign next_q = (req_qid == LAST_Q) ? '0 : req_qid + QID_WIDTH'(1);

    rr_pick #(
        .NUM_Q     (NUM_Q),
        .QID_WIDTH (QID_WIDTH)
    ) u_rr_pick (
        .elig  (elig),
        .start (rr_ptr),
        .found (pick_found),
        .qid   (pick_qid)
    );

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            req_qid   <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            req_qid   <= req_qid_d;
            burst_cnt <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        req_qid_d   = req_qid;
        burst_cnt_d = burst_cnt;
        dec         = '0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    req_qid_d   = pick_qid;
                    burst_cnt_d = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // A handshake takes precedence over a same-cycle loss of readiness.
                if (sched_if.req_rdy) begin
                    dec[req_qid] = 1'b1;
                    burst_cnt_d  = burst_cnt + BURST_W'(1);
                    if (burst_cnt == BURST_LAST || !cur_ok) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_q;
                    end
                end else if (!cur_ok) begin
                    abort    = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = next_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sched_if.req_vld    = (state == ISSUE);
    assign sched_if.req_qid    = req_qid;
    assign sched_if.req_last   = (state == ISSUE) && (burst_cnt == BURST_LAST);
    assign sched_if.q_desc_dec = dec;
    assign sched_if.req_abort  = abort;
    assign sched_if.sched_busy = (state != IDLE);

`ifdef QDMA_DESC_SCHED_STATS_EN
    localparam logic [QID_WIDTH:0] NUM_Q_W = (QID_WIDTH+1)'(NUM_Q);

    logic [STAT_WIDTH-1:0] stat_mem [NUM_Q];
    logic                  hs;

    assign hs = (state == ISSUE) && sched_if.req_rdy;

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            for (int unsigned i = 0; i < NUM_Q; i++) stat_mem[i] <= '0;
        end else if (stat_clr) begin
            for (int unsigned i = 0; i < NUM_Q; i++) stat_mem[i] <= '0;
        end else if (hs && (stat_mem[req_qid] != '1)) begin
            stat_mem[req_qid] <= stat_mem[req_qid] + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            stat_cnt <= '0;
        end else if ({1'b0, stat_qid} < NUM_Q_W) begin
            stat_cnt <= stat_mem[stat_qid];
        end else begin
            stat_cnt <= '0;
        end
    end
`endif

endmodule
